// File: rtl/gcd_iter_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gcd_iter_unit : iterative GCD engine (subtractive Euclid or binary Stein)   |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module gcd_iter_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int MODE       = 0,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  nreset_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] gcd_o,
  output logic                  zero_o,
  output logic [CNT_WIDTH-1:0]  cycles_o
);

  localparam int c_K_WIDTH = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [c_K_WIDTH-1:0]  r_k;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_gcd;
  logic                  r_zero;
  logic [CNT_WIDTH-1:0]  r_cycles;
  logic                  r_in_ready;
  logic                  r_out_valid;

  logic [DATA_WIDTH-1:0] w_a_next;
  logic [DATA_WIDTH-1:0] w_b_next;
  logic [c_K_WIDTH-1:0]  w_k_next;
  logic [DATA_WIDTH-1:0] w_result;
  logic [CNT_WIDTH-1:0]  w_cnt_inc;
  logic                  w_accept;
  logic                  w_op_zero;

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_accept  = in_valid_i && r_in_ready;
  assign w_op_zero = (operand_a_i == '0) || (operand_b_i == '0);

  // One reduction step per cycle; only meaningful while a != b.
  generate
    if (MODE == 0) begin : g_euclid
      assign w_result = r_a;
      always_comb begin
        w_a_next = r_a;
        w_b_next = r_b;
        w_k_next = r_k;
        if (r_a > r_b) begin
          w_a_next = r_a - r_b;
        end else if (r_b > r_a) begin
          w_b_next = r_b - r_a;
        end
      end
    end else begin : g_stein
      assign w_result = r_a << r_k;
      always_comb begin
        w_a_next = r_a;
        w_b_next = r_b;
        w_k_next = r_k;
        if (!r_a[0] && !r_b[0]) begin
          w_a_next = r_a >> 1;
          w_b_next = r_b >> 1;
          w_k_next = r_k + 1'b1;
        end else if (!r_a[0]) begin
          w_a_next = r_a >> 1;
        end else if (!r_b[0]) begin
          w_b_next = r_b >> 1;
        end else if (r_a > r_b) begin
          w_a_next = r_a - r_b;
        end else begin
          w_b_next = r_b - r_a;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_k         <= '0;
      r_cnt       <= '0;
      r_gcd       <= '0;
      r_zero      <= 1'b0;
      r_cycles    <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_a        <= operand_a_i;
            r_b        <= operand_b_i;
            r_k        <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            if (w_op_zero) begin
              r_gcd       <= operand_a_i | operand_b_i;
              r_zero      <= (operand_a_i == '0) && (operand_b_i == '0);
              r_cycles    <= '0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_cnt <= w_cnt_inc;
          if (r_a == r_b) begin
            // The terminating compare cycle is counted in the reported total.
            r_gcd       <= w_result;
            r_zero      <= 1'b0;
            r_cycles    <= w_cnt_inc;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_a <= w_a_next;
            r_b <= w_b_next;
            r_k <= w_k_next;
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign gcd_o       = r_gcd;
  assign zero_o      = r_zero;
  assign cycles_o    = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_gcd_iter_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gcd_iter_unit : scoreboard bench over Euclid, Stein and narrow-counter   |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_gcd_iter_unit;

  typedef struct {
    int g;
    int z;
    int c;
    int lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       nreset;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [1:0] sel;

  logic [2:0] in_ready_v;
  logic [2:0] out_valid_v;
  logic [2:0] zero_v;
  logic [7:0] gcd0, gcd1, gcd2;
  logic [7:0] cyc0, cyc1;
  logic [3:0] cyc2;

  logic       w_in_ready, w_out_valid, w_zero;
  logic [7:0] w_gcd, w_cycles;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  gcd_iter_unit #(.DATA_WIDTH(8), .MODE(0), .CNT_WIDTH(8)) u_euclid (
    .clk_i(clk), .nreset_i(nreset), .in_valid_i(in_valid && sel == 2'd0),
    .in_ready_o(in_ready_v[0]), .operand_a_i(op_a), .operand_b_i(op_b),
    .out_valid_o(out_valid_v[0]), .out_ready_i(out_ready), .gcd_o(gcd0),
    .zero_o(zero_v[0]), .cycles_o(cyc0)
  );

  gcd_iter_unit #(.DATA_WIDTH(8), .MODE(1), .CNT_WIDTH(8)) u_stein (
    .clk_i(clk), .nreset_i(nreset), .in_valid_i(in_valid && sel == 2'd1),
    .in_ready_o(in_ready_v[1]), .operand_a_i(op_a), .operand_b_i(op_b),
    .out_valid_o(out_valid_v[1]), .out_ready_i(out_ready), .gcd_o(gcd1),
    .zero_o(zero_v[1]), .cycles_o(cyc1)
  );

  gcd_iter_unit #(.DATA_WIDTH(8), .MODE(0), .CNT_WIDTH(4)) u_narrow (
    .clk_i(clk), .nreset_i(nreset), .in_valid_i(in_valid && sel == 2'd2),
    .in_ready_o(in_ready_v[2]), .operand_a_i(op_a), .operand_b_i(op_b),
    .out_valid_o(out_valid_v[2]), .out_ready_i(out_ready), .gcd_o(gcd2),
    .zero_o(zero_v[2]), .cycles_o(cyc2)
  );

  always_comb begin
    w_in_ready  = in_ready_v[0];
    w_out_valid = out_valid_v[0];
    w_zero      = zero_v[0];
    w_gcd       = gcd0;
    w_cycles    = cyc0;
    case (sel)
      2'd1: begin
        w_in_ready  = in_ready_v[1];
        w_out_valid = out_valid_v[1];
        w_zero      = zero_v[1];
        w_gcd       = gcd1;
        w_cycles    = cyc1;
      end
      2'd2: begin
        w_in_ready  = in_ready_v[2];
        w_out_valid = out_valid_v[2];
        w_zero      = zero_v[2];
        w_gcd       = gcd2;
        w_cycles    = {4'd0, cyc2};
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference algorithm: sel 1 is the binary variant, sel 2 has a 4-bit counter.
  function automatic exp_t model(input logic [1:0] s, input int a, input int b);
    exp_t e;
    int   n = 0;
    int   k = 0;
    int   sat;
    sat = (s == 2'd2) ? 15 : 255;
    if (a == 0 || b == 0) begin
      e.g = a | b;
      e.z = (a == 0 && b == 0) ? 1 : 0;
      e.c = 0;
      e.lat = 1;
      return e;
    end
    while (a != b) begin
      if (s == 2'd1 && a % 2 == 0 && b % 2 == 0) begin
        a = a / 2; b = b / 2; k++;
      end else if (s == 2'd1 && a % 2 == 0) begin
        a = a / 2;
      end else if (s == 2'd1 && b % 2 == 0) begin
        b = b / 2;
      end else if (a > b) begin
        a = a - b;
      end else begin
        b = b - a;
      end
      n++;
    end
    n++;
    e.g = a * (1 << k);
    e.z = 0;
    e.c = (n > sat) ? sat : n;
    e.lat = n + 1;
    return e;
  endfunction

  task automatic push_exp(input int g, input int z, input int c, input int lat);
    exp_t e;
    e.g = g; e.z = z; e.c = c; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic send(input logic [1:0] s, input int a, input int b);
    int n = 0;
    @(negedge clk);
    sel = s; op_a = a[7:0]; op_b = b[7:0]; in_valid = 1'b1;
    while (!w_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic receive(input int hold, input bit churn);
    exp_t e;
    int   lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!w_out_valid && lat < 400);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check("out_valid", w_out_valid, 1);
    check("gcd", w_gcd, e.g);
    check("zero", w_zero, e.z);
    check("cycles", w_cycles, e.c);
    check("latency", lat, e.lat);
    for (int i = 0; i < hold; i++) begin
      if (churn) begin
        in_valid = 1'b1;
        op_a = 8'($urandom_range(1, 255));
        op_b = 8'($urandom_range(1, 255));
      end
      @(negedge clk);
      check("hold_gcd", w_gcd, e.g);
      check("hold_cycles", w_cycles, e.c);
      check("hold_valid", w_out_valid, 1);
      check("hold_ready", w_in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_valid", w_out_valid, 0);
    check("post_hs_ready", w_in_ready, 1);
  endtask

  task automatic run_model(input logic [1:0] s, input int a, input int b);
    exp_t e;
    e = model(s, a, b);
    sb.push_back(e);
    send(s, a, b);
    receive(0, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    nreset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; sel = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_gcd", w_gcd, 0);
    check("rst_zero", w_zero, 0);
    check("rst_cycles", w_cycles, 0);
    check("rst_valid", w_out_valid, 0);
    nreset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", w_in_ready, 1);

    push_exp(6, 0, 5, 6);    send(2'd0, 48, 18); receive(0, 1'b0);
    push_exp(35, 0, 0, 1);   send(2'd0, 0, 35);  receive(0, 1'b0);
    push_exp(0, 1, 0, 1);    send(2'd0, 0, 0);   receive(0, 1'b0);
    push_exp(6, 0, 5, 6);    send(2'd0, 48, 18); receive(0, 1'b0);
    push_exp(1, 0, 255, 256); send(2'd0, 255, 1); receive(0, 1'b0);

    // Backpressure with a live source; the pair presented right after release is taken.
    push_exp(6, 0, 5, 6);    send(2'd0, 48, 18); receive(10, 1'b1);
    op_a = 8'd20; op_b = 8'd15;
    sb.push_back(model(2'd0, 20, 15));
    @(posedge clk);
    #1 in_valid = 1'b0;
    receive(0, 1'b0);

    // Abort mid-calculation.
    send(2'd0, 200, 3);
    repeat (4) @(negedge clk);
    nreset = 1'b0;
    #1;
    check("abort_gcd", w_gcd, 0);
    check("abort_cycles", w_cycles, 0);
    check("abort_valid", w_out_valid, 0);
    check("abort_zero", w_zero, 0);
    @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_ready", w_in_ready, 1);
    push_exp(4, 0, 3, 4);    send(2'd0, 12, 8);  receive(0, 1'b0);

    push_exp(6, 0, 7, 8);    send(2'd1, 48, 18); receive(0, 1'b0);
    push_exp(32, 0, 9, 10);  send(2'd1, 64, 96); receive(0, 1'b0);
    push_exp(0, 1, 0, 1);    send(2'd1, 0, 0);   receive(0, 1'b0);
    push_exp(128, 0, 1, 2);  send(2'd1, 128, 128); receive(0, 1'b0);

    push_exp(1, 0, 15, 256); send(2'd2, 255, 1); receive(0, 1'b0);
    push_exp(6, 0, 5, 6);    send(2'd2, 48, 18); receive(0, 1'b0);

    for (int i = 0; i < 15; i++) begin
      run_model(2'd0, $urandom_range(0, 255), $urandom_range(0, 255));
      run_model(2'd1, $urandom_range(0, 255), $urandom_range(0, 255));
    end
    for (int i = 0; i < 5; i++) begin
      run_model(2'd2, $urandom_range(1, 255), $urandom_range(1, 255));
    end

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
